// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation-engine arbiter: FSM state
// encodings, the default operand width and the round-robin search helper.
package rsa_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam int DEFAULT_WIDTH = 2048;
   localparam int MAX_REQ       = 8;

   // Returns {found, index}: the first set request strictly after ptr,
   // wrapping cyclically over nreq requesters (ptr itself is searched last).
   function automatic logic [3:0] rrNextGrant(input logic [7:0] req,
                                              input logic [2:0] ptr,
                                              input int         nreq);
      logic [3:0] res;
      int         k;
      res = '0;
      k   = 0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         if ((i <= nreq) && !res[3]) begin
            k = (int'(ptr) + i) % nreq;
            if (req[k[2:0]]) begin
               res = {1'b1, k[2:0]};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Round-robin grant selection. The next grant is combinational from the
// request vector and the pointer; the pointer moves to the granted requester
// only when the parent strobes update, so requester 0 wins first after reset.
module rsa_rr_arbiter
   import rsa_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            sys_rst,
   input  logic [NREQ-1:0] reqVec_i,
   input  logic            update_i,
   output logic [2:0]      grantIdx_o,
   output logic            grantValid_o
);

   logic [2:0] ptr_q;
   logic [2:0] ptr_d;
   logic [3:0] nextGrant;

   // Cyclic search for the first active request after the pointer.
   always_comb begin
      nextGrant    = rrNextGrant(8'(reqVec_i), ptr_q, NREQ);
      grantValid_o = nextGrant[3];
      grantIdx_o   = nextGrant[2:0];
      ptr_d        = ptr_q;
      if (update_i && nextGrant[3]) begin
         ptr_d = nextGrant[2:0];
      end
   end

   // Pointer register; resets to the last requester so the search starts at 0.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         ptr_q <= 3'(NREQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rsa_exp_arbiter.sv
// Shares one modular-exponentiation engine between NREQ requesters: grants a
// requester round-robin, latches its operands, pulses the engine start, waits
// for finish under a watchdog and returns the result over valid/ready.
module rsa_exp_arbiter
   import rsa_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 16777216,
   parameter int CNT_W   = 25
) (
   input  logic                  clk,
   input  logic                  sys_rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_c,
   input  logic [NREQ*WIDTH-1:0] req_e,
   input  logic [NREQ*WIDTH-1:0] req_n,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_err,
   output logic [WIDTH-1:0]      eng_c,
   output logic [WIDTH-1:0]      eng_e,
   output logic [WIDTH-1:0]      eng_n,
   output logic                  eng_rst,
   input  logic                  eng_finish,
   input  logic [WIDTH-1:0]      eng_result,
   output logic                  busy
);

   logic [1:0]       state_q, state_d;
   logic [2:0]       owner_q, owner_d;
   logic [WIDTH-1:0] engC_q, engC_d;
   logic [WIDTH-1:0] engE_q, engE_d;
   logic [WIDTH-1:0] engN_q, engN_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             engRst_q, engRst_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;

   logic [2:0]       grantIdx;
   logic             grantValid;
   logic             grantTake;
   logic             ownerReady;
   logic [WIDTH-1:0] selC, selE, selN;

   // A grant is only taken in IDLE and never while reset is being applied.
   assign grantTake = (state_q == IDLE) && grantValid && !sys_rst;

   rsa_rr_arbiter #(
      .NREQ(NREQ)
   ) uArb (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .reqVec_i    (req_valid),
      .update_i    (grantTake),
      .grantIdx_o  (grantIdx),
      .grantValid_o(grantValid)
   );

   // Operand mux for the granted requester, one-hot handshakes and owner ready.
   always_comb begin
      selC       = '0;
      selE       = '0;
      selN       = '0;
      ownerReady = 1'b0;
      req_ready  = '0;
      rsp_valid  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grantIdx == 3'(k)) begin
            selC = req_c[k*WIDTH +: WIDTH];
            selE = req_e[k*WIDTH +: WIDTH];
            selN = req_n[k*WIDTH +: WIDTH];
            req_ready[k] = grantTake;
         end
         if (owner_q == 3'(k)) begin
            ownerReady   = rsp_ready[k];
            rsp_valid[k] = (state_q == RESP);
         end
      end
   end

   // Transaction FSM: accept/bypass, engine start, run with watchdog, respond.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      engC_d   = engC_q;
      engE_d   = engE_q;
      engN_d   = engN_q;
      result_d = result_q;
      err_d    = err_q;
      engRst_d = 1'b0;
      wdog_d   = wdog_q;
      case (state_q)
         IDLE: begin
            if (grantTake) begin
               owner_d = grantIdx;
               engC_d  = selC;
               engE_d  = selE;
               engN_d  = selN;
               if (selN == '0) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = RESP;
               end else if (selE == '0) begin
                  result_d = WIDTH'(1);
                  err_d    = 1'b0;
                  state_d  = RESP;
               end else begin
                  engRst_d = 1'b1;
                  state_d  = LOAD;
               end
            end
         end
         LOAD: begin
            wdog_d  = '0;
            state_d = RUN;
         end
         RUN: begin
            wdog_d = wdog_q + CNT_W'(1);
            if ((wdog_q != '0) && eng_finish) begin
               result_d = eng_result;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (wdog_d == CNT_W'(TIMEOUT)) begin
               engRst_d = 1'b1;
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         default: begin
            if (ownerReady) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         engC_q   <= '0;
         engE_q   <= '0;
         engN_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         engRst_q <= 1'b0;
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         engC_q   <= engC_d;
         engE_q   <= engE_d;
         engN_q   <= engN_d;
         result_q <= result_d;
         err_q    <= err_d;
         engRst_q <= engRst_d;
         wdog_q   <= wdog_d;
      end
   end

   assign eng_c      = engC_q;
   assign eng_e      = engE_q;
   assign eng_n      = engN_q;
   assign eng_rst    = engRst_q;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Directed bench for rsa_exp_arbiter with a small behavioural engine that can
// also be forced to a stuck-low or stuck-high finish.
module tb_rsa_exp_arbiter;

   localparam int W       = 16;
   localparam int NR      = 2;
   localparam int TO      = 100;
   localparam int CW      = 8;
   localparam int ENG_LAT = 5;

   logic            clk = 1'b0;
   logic            sys_rst;
   logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NR*W-1:0] req_c, req_e, req_n;
   logic [W-1:0]    rsp_result, eng_c, eng_e, eng_n, eng_result;
   logic            rsp_err, eng_rst, eng_finish, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int engMode = 0;
   int rstCount = 0;
   int grantLog[$];
   int rspOwner[$];
   int rspRes[$];
   int acceptCyc, rst0;

   logic         modelFin = 1'b0;
   logic [W-1:0] modelRes = '0;
   int           engCnt   = 0;

   rsa_exp_arbiter #(.WIDTH(W), .NREQ(NR), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .sys_rst(sys_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_c(req_c), .req_e(req_e), .req_n(req_n),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .eng_c(eng_c), .eng_e(eng_e), .eng_n(eng_n),
      .eng_rst(eng_rst), .eng_finish(eng_finish), .eng_result(eng_result),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] modexp(input logic [W-1:0] c, e, n);
      longint r;
      if (n == 0) return '0;
      r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * longint'(c)) % longint'(n);
      return W'(r);
   endfunction

   // Behavioural engine: loads on eng_rst, raises finish ENG_LAT cycles later.
   always @(posedge clk) begin
      if (eng_rst) begin
         modelFin <= 1'b0;
         modelRes <= modexp(eng_c, eng_e, eng_n);
         engCnt   <= ENG_LAT;
      end else if (engCnt > 0) begin
         engCnt <= engCnt - 1;
         if (engCnt == 1) modelFin <= 1'b1;
      end
   end

   assign eng_finish = (engMode == 0) ? modelFin : (engMode == 2);
   assign eng_result = modelRes;

   // Cycle counter plus logs of grants, engine pulses and completed responses.
   always @(posedge clk) begin
      cyc++;
      if (req_ready == 2'b01) grantLog.push_back(0);
      else if (req_ready == 2'b10) grantLog.push_back(1);
      if (eng_rst) rstCount++;
      if ((rsp_valid & rsp_ready) != 0) begin
         rspOwner.push_back((rsp_valid == 2'b10) ? 1 : 0);
         rspRes.push_back(int'(rsp_result));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int k, input logic [W-1:0] c, e, n, input logic v);
      req_c[k*W +: W] = c;
      req_e[k*W +: W] = e;
      req_n[k*W +: W] = n;
      req_valid[k]    = v;
   endtask

   task automatic waitRsp(input int budget);
      int n = 0;
      while (rsp_valid == 0 && n < budget) begin
         tick();
         n++;
      end
      if (rsp_valid == 0) begin
         total++;
         bad++;
         $error("[TB] FAIL wait_rsp: observed=no response expected=response within %0d cycles", budget);
      end
   endtask

   function automatic int qGet(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   initial begin
      sys_rst = 1'b1; req_valid = '0; rsp_ready = 2'b11;
      req_c = '0; req_e = '0; req_n = '0;
      tick(); tick();
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_result", rsp_result, 0);
      checkOutput("rst_err", rsp_err, 0);
      checkOutput("rst_eng_c", eng_c, 0);
      checkOutput("rst_eng_rst", eng_rst, 0);
      checkOutput("rst_busy", busy, 0);
      sys_rst = 1'b0;
      tick();

      // Contention: both requesters hold 2^10 mod 1000 = 24.
      grantLog.delete(); rspOwner.delete(); rspRes.delete();
      applyStimulus(0, 2, 10, 1000, 1'b1);
      applyStimulus(1, 2, 10, 1000, 1'b1);
      for (int i = 0; i < 300 && rspOwner.size() < 4; i++) tick();
      req_valid = '0;
      checkOutput("cont_count", rspOwner.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("cont_grant%0d", i), qGet(grantLog, i), i % 2);
         checkOutput($sformatf("cont_owner%0d", i), qGet(rspOwner, i), i % 2);
         checkOutput($sformatf("cont_result%0d", i), qGet(rspRes, i), 24);
      end
      tick();

      // Single request: 4^13 mod 497 = 445.
      rst0 = rstCount;
      applyStimulus(0, 4, 13, 497, 1'b1);
      #1;
      checkOutput("single_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      checkOutput("single_eng_rst", eng_rst, 1);
      checkOutput("single_busy", busy, 1);
      checkOutput("single_eng_c", eng_c, 4);
      checkOutput("single_eng_e", eng_e, 13);
      checkOutput("single_eng_n", eng_n, 497);
      tick();
      checkOutput("single_eng_rst_low", eng_rst, 0);
      waitRsp(50);
      checkOutput("single_valid", rsp_valid, 2'b01);
      checkOutput("single_result", rsp_result, 445);
      checkOutput("single_err", rsp_err, 0);
      tick();
      checkOutput("single_rst_pulses", rstCount - rst0, 1);
      checkOutput("single_idle", busy, 0);

      // Bypass e==0 on requester 0: result 1, engine untouched.
      rst0 = rstCount;
      applyStimulus(0, 7, 0, 11, 1'b1);
      #1;
      checkOutput("byp_e_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      checkOutput("byp_e_valid", rsp_valid, 2'b01);
      checkOutput("byp_e_result", rsp_result, 1);
      checkOutput("byp_e_err", rsp_err, 0);
      tick();
      checkOutput("byp_e_no_eng_rst", rstCount - rst0, 0);

      // Bypass n==0 on requester 1: error, result 0.
      applyStimulus(1, 7, 3, 0, 1'b1);
      tick();
      req_valid = '0;
      checkOutput("byp_n_valid", rsp_valid, 2'b10);
      checkOutput("byp_n_result", rsp_result, 0);
      checkOutput("byp_n_err", rsp_err, 1);
      tick();

      // Timeout: finish stuck low; abort pulse after TO RUN cycles.
      engMode = 1;
      rst0 = rstCount;
      applyStimulus(0, 3, 5, 7, 1'b1);
      #1;
      acceptCyc = cyc;
      checkOutput("to_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      waitRsp(300);
      checkOutput("to_latency", cyc - acceptCyc, 2 + TO);
      checkOutput("to_abort_rst", eng_rst, 1);
      checkOutput("to_err", rsp_err, 1);
      checkOutput("to_result", rsp_result, 0);
      tick();
      checkOutput("to_rst_pulses", rstCount - rst0, 2);

      // Finish stuck high: ignored in the first RUN cycle, taken in the second.
      engMode = 2;
      applyStimulus(1, 3, 4, 50, 1'b1);
      #1;
      acceptCyc = cyc;
      checkOutput("stuck1_ready", req_ready, 2'b10);
      tick();
      req_valid = '0;
      waitRsp(20);
      checkOutput("stuck1_latency", cyc - acceptCyc, 4);
      checkOutput("stuck1_result", rsp_result, 31);
      checkOutput("stuck1_err", rsp_err, 0);
      engMode = 0;
      tick();

      // Backpressure: owner 0 stalls, requester 1 waits for the handshake.
      rsp_ready = 2'b00;
      applyStimulus(0, 4, 13, 497, 1'b1);
      applyStimulus(1, 2, 10, 1000, 1'b1);
      #1;
      checkOutput("bp_ready", req_ready, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      waitRsp(50);
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_hold_valid%0d", i), rsp_valid, 2'b01);
         checkOutput($sformatf("bp_hold_result%0d", i), rsp_result, 445);
         checkOutput($sformatf("bp_hold_noGrant%0d", i), req_ready, 0);
         tick();
      end
      rsp_ready = 2'b01;
      #1;
      checkOutput("bp_hs_noGrant", req_ready, 0);
      tick();
      rsp_ready = 2'b11;
      checkOutput("bp_idle_busy", busy, 0);
      checkOutput("bp_grant1", req_ready, 2'b10);
      tick();
      req_valid = '0;
      waitRsp(50);
      checkOutput("bp_valid1", rsp_valid, 2'b10);
      checkOutput("bp_result1", rsp_result, 24);
      tick();

      // Reset mid-RUN aborts silently and re-arms the pointer to requester 0.
      applyStimulus(0, 4, 13, 497, 1'b1);
      tick();
      req_valid = '0;
      tick();
      checkOutput("mr_in_run", busy, 1);
      sys_rst = 1'b1;
      applyStimulus(0, 4, 13, 497, 1'b1);
      applyStimulus(1, 2, 10, 1000, 1'b1);
      tick();
      checkOutput("mr_busy", busy, 0);
      checkOutput("mr_eng_rst", eng_rst, 0);
      checkOutput("mr_eng_c", eng_c, 0);
      checkOutput("mr_rsp_valid", rsp_valid, 0);
      checkOutput("mr_gated_ready", req_ready, 0);
      sys_rst = 1'b0;
      #1;
      checkOutput("mr_grant0", req_ready, 2'b01);
      tick();
      req_valid = '0;
      waitRsp(50);
      checkOutput("mr_owner", rsp_valid, 2'b01);
      checkOutput("mr_result", rsp_result, 445);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rsa_exp_arbiter.md
Name: rsa_exp_arbiter

Overview:
Shares one modular-exponentiation engine (operands c, e, n; result c^e mod n) between NREQ requesters.
- Round-robin arbitration between requesters.
- Latches the winning operand set and pulses the engine's start/reset.
- Waits for engine finish, with a watchdog timeout.
- Returns the result to the owning requester over a valid/ready handshake.
- Sits between the RSA command front-end and the exponentiation datapath.

Parameters:
WIDTH, 2048, operand/result width in bits
NREQ, 2, number of requesters (2..8)
TIMEOUT, 16777216, max engine cycles before abort
CNT_W, 25, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot accept pulse
req_c  in  NREQ*WIDTH  base, requester k at bits [k*WIDTH +: WIDTH]
req_e  in  NREQ*WIDTH  exponent, same packing
req_n  in  NREQ*WIDTH  modulus, same packing
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  per-requester response ready
rsp_result  out  WIDTH  shared result bus
rsp_err  out  1  response is an error (n==0 or timeout)
eng_c / eng_e / eng_n  out  WIDTH each  registered operands to engine
eng_rst  out  1  engine start/abort pulse (engine loads operands while high)
eng_finish  in  1  engine done level
eng_result  in  WIDTH  engine result
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk). Reset sys_rst is synchronous and active-high.
- While sys_rst is high at a clk edge, all outputs go to 0 and the state goes to IDLE.
  - Round-robin pointer resets to NREQ-1, so requester 0 wins first.
  - Reset during any state, including RUN, aborts the transaction; no response is issued.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid is set, grant the first requester after the pointer, searching cyclically.
  - req_ready[g]=1 for exactly that cycle; latch c/e/n of requester g into eng_* and the owner register.
  - Update the pointer to g.
  - Next state depends on the latched operands:
    - n==0: RESP with err=1, result=0.
    - else e==0: RESP with err=0, result=1. The engine is not used.
    - else LOAD.
- LOAD:
  - Exactly one cycle with eng_rst=1; watchdog cleared.
  - Then RUN.
- RUN:
  - eng_rst=0; watchdog increments each cycle.
  - eng_finish is ignored in the first RUN cycle, because it may be stale.
  - From the second cycle on, eng_finish=1 latches eng_result → RESP, err=0.
  - If the watchdog reaches TIMEOUT first: one-cycle eng_rst=1 (abort), result=0, err=1 → RESP.
  - If finish and timeout happen in the same cycle, finish wins.
- RESP:
  - rsp_valid[owner]=1; rsp_result and rsp_err are held stable until rsp_ready[owner]=1.
  - On handshake → IDLE. No new grant in the handshake cycle, so there is at least one idle cycle between transactions.
  - rsp_ready of other requesters is ignored.
- req_ready is never asserted outside IDLE. Requesters must hold their operands stable while req_valid is high.
- Latency, for a nonzero-e request accepted at cycle T with no contention:
  - eng_rst high at T+1.
  - Earliest rsp_valid at T+3 + engine time.
  - Bypass (e==0 or n==0): rsp_valid at T+1.
- Width rules:
  - Operands are passed unmodified.
  - No reduction of c mod n; the engine requires c<n.

Decomposition:
- Package rsa_pkg holds:
  - state encoding localparams: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RESP=2'd3;
  - default WIDTH;
  - helper function for the round-robin next-grant.
- One sub-module: rsa_rr_arbiter. It is combinational next-grant from the req vector and the pointer, with the pointer register and an update strobe. The parent holds the FSM, operand registers and watchdog.

Test Plan:
- Single request, behavioural engine model: req0 c=4, e=13, n=497 → req_ready[0] pulse, eng_rst high exactly one cycle, rsp_valid[0] with rsp_result=445, rsp_err=0.
- Contention: req0 and req1 both valid continuously, all c=2, e=10, n=1000 →
  - grants alternate 0,1,0,1;
  - each rsp_result=24;
  - responses routed one-hot to the correct owner.
- Bypass cases:
  - c=7, e=0, n=11 → result=1, err=0, rsp_valid one cycle after accept, eng_rst never asserted.
  - c=7, e=3, n=0 → result=0, err=1.
- Timeout: stub engine with eng_finish stuck 0, TIMEOUT=100 →
  - abort eng_rst pulse after 100 RUN cycles, then rsp_err=1, result=0.
  - Variant with eng_finish stuck 1: not accepted in the first RUN cycle; accepted in the second.
- Backpressure: rsp_ready[0] low for 5 cycles after rsp_valid → result and err held, no new grant despite req1 valid; grant to 1 follows after the handshake and one idle cycle.
- Reset mid-RUN: assert sys_rst for 1 cycle during RUN → all outputs 0, busy=0; next contended request grants requester 0.
